// File: rtl/corr_pkg.sv
// Shared types and width helpers for the sample correlator.
// CORR_SIGNED_EN (top-level build macro) selects signed vs unsigned sample arithmetic.
package corr_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUT     = 2'd2
  } state_e;

  localparam int DEPTH_DEF    = 16;
  localparam int SAMPLE_W_DEF = 8;
  localparam int PTR_W        = $clog2(DEPTH_DEF);

  // Widest sum of DEPTH full-precision products: 2*SAMPLE_W product bits plus log2(DEPTH) growth.
  function automatic int acc_width(input int sample_w, input int depth);
    return 2 * sample_w + $clog2(depth);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sample_ring.sv
// Dual-channel circular sample window: one write port, one combinational read port.
// Tracks fill level; once full, new pairs overwrite the oldest slot.
module sample_ring
  import corr_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int DEPTH    = 16,
  parameter int PW       = ptr_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                clear,
  input  logic                wr_en,
  input  logic [SAMPLE_W-1:0] wr_a,
  input  logic [SAMPLE_W-1:0] wr_b,
  input  logic [PW-1:0]       rd_ptr,
  output logic [SAMPLE_W-1:0] rd_a,
  output logic [SAMPLE_W-1:0] rd_b,
  output logic [PW-1:0]       oldest,
  output logic                full
);

  logic [DEPTH-1:0][SAMPLE_W-1:0] mem_a;
  logic [DEPTH-1:0][SAMPLE_W-1:0] mem_b;
  logic [PW-1:0]                  wr_ptr;
  logic [PW:0]                    count;
  logic                           wr_go;

  assign wr_go = ena & wr_en & ~clear;

  always_ff @(posedge clk) begin
    if (wr_go) begin
      mem_a[wr_ptr] <= wr_a;
      mem_b[wr_ptr] <= wr_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (ena) begin
      if (clear) begin
        wr_ptr <= '0;
        count  <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (!full) count <= count + (PW+1)'(1);
      end
    end
  end

  assign full = (count == (PW+1)'(DEPTH));

  // Oldest slot as seen after this cycle's write, so a same-cycle sample joins the window.
  assign oldest = (wr_en && !clear) ? wr_ptr + PW'(1) : wr_ptr;

  assign rd_a = mem_a[rd_ptr];
  assign rd_b = mem_b[rd_ptr];

endmodule

// File: rtl/sample_correlator.sv
// Streaming dual-channel correlator: sliding window plus one MAC per cycle dot product.
// Build macro CORR_SIGNED_EN: when defined, samples/products/result are two's complement.
module sample_correlator
  import corr_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int DEPTH    = 16,
  parameter int ACC_W    = acc_width(SAMPLE_W, DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_a,
  input  logic [SAMPLE_W-1:0] in_b,
  output logic                full,
  input  logic                start,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_data
);

  localparam int PW = ptr_width(DEPTH);
  localparam int PROD_W = 2 * SAMPLE_W;

  state_e              state, state_nxt;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       mac_cnt;
  logic [PW-1:0]       oldest;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_nxt;
  logic [ACC_W-1:0]    prod_ext;
  logic [SAMPLE_W-1:0] rd_a, rd_b;
  logic                load, ring_wr, ring_clr, start_ok, mac_last;

  assign load     = (state == LOAD);
  assign ring_wr  = load & in_valid;
  assign ring_clr = load & clear;
  assign start_ok = load & start & full & ~clear;
  assign mac_last = (mac_cnt == PW'(DEPTH - 1));

  sample_ring #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH)
  ) u_ring (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .clear  (ring_clr),
    .wr_en  (ring_wr),
    .wr_a   (in_a),
    .wr_b   (in_b),
    .rd_ptr (rd_ptr),
    .rd_a   (rd_a),
    .rd_b   (rd_b),
    .oldest (oldest),
    .full   (full)
  );

`ifdef CORR_SIGNED_EN
  logic signed [PROD_W-1:0] prod;
  assign prod     = $signed(rd_a) * $signed(rd_b);
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
`else
  logic [PROD_W-1:0] prod;
  assign prod     = rd_a * rd_b;
  assign prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod};
`endif

  assign acc_nxt = acc + prod_ext;

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (start_ok) state_nxt = COMPUTE;
      COMPUTE: if (mac_last) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      rd_ptr    <= '0;
      mac_cnt   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ena) begin
      state <= state_nxt;
      case (state)
        LOAD: begin
          if (start_ok) begin
            acc     <= '0;
            rd_ptr  <= oldest;
            mac_cnt <= '0;
          end
        end
        COMPUTE: begin
          acc     <= acc_nxt;
          rd_ptr  <= rd_ptr + PW'(1);
          mac_cnt <= mac_cnt + PW'(1);
          // Result register loads with the final sum so out_data is valid with out_valid.
          if (mac_last) begin
            out_data  <= acc_nxt;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = load;
  assign busy     = ~load;

endmodule

// File: tb/tb_sample_correlator.sv
// Scoreboard bench for sample_correlator: queue-based window model, decoupled result monitor.
module tb_sample_correlator;
  import corr_pkg::*;

  localparam int SW = 8;
  localparam int D  = 16;
  localparam int AW = acc_width(SW, D);

  logic          clk, rst_n, ena, clear, in_valid, in_ready, full, start, busy;
  logic          out_valid, out_ready;
  logic [SW-1:0] in_a, in_b;
  logic [AW-1:0] out_data;

  sample_correlator #(.SAMPLE_W(SW), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .full      (full),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int nres  = 0;
  bit rnd_ena = 0;

  logic [AW-1:0] sb[$];
  logic [SW-1:0] wa[$];
  logic [SW-1:0] wb[$];
  logic          hold_q = 1'b0;
  logic [AW-1:0] hold_d;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: last D accepted pairs, dot product in plain integer arithmetic.
  function automatic logic [AW-1:0] dot();
    longint s;
    s = 0;
    foreach (wa[i]) begin
`ifdef CORR_SIGNED_EN
      s += longint'($signed(wa[i])) * longint'($signed(wb[i]));
`else
      s += longint'(wa[i]) * longint'(wb[i]);
`endif
    end
    return s[AW-1:0];
  endfunction

  function automatic void mpush(input logic [SW-1:0] a, input logic [SW-1:0] b);
    wa.push_back(a);
    wb.push_back(b);
    if (wa.size() > D) begin
      void'(wa.pop_front());
      void'(wb.pop_front());
    end
  endfunction

  function automatic void mclear();
    wa.delete();
    wb.delete();
  endfunction

  // Monitor: checks each completed result handshake and stability while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_d);
      end
      if (out_valid && out_ready && ena) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else chk("result", out_data, sb.pop_front());
        nres++;
      end
      hold_q = out_valid && !(out_ready && ena);
      hold_d = out_data;
    end
  end

  task automatic push(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic e;
    in_valid = 1'b1; in_a = a; in_b = b;
    do begin
      e = rnd_ena ? ($urandom_range(0, 3) != 0) : 1'b1;
      ena = e;
      @(posedge clk); #1;
    end while (!e);
    in_valid = 1'b0; ena = 1'b1;
    mpush(a, b);
  endtask

  task automatic try_start(output bit acc_ok);
    logic e;
    start = 1'b1;
    do begin
      e = rnd_ena ? ($urandom_range(0, 3) != 0) : 1'b1;
      ena = e;
      @(posedge clk); #1;
    end while (!e);
    start = 1'b0; ena = 1'b1;
    acc_ok = (wa.size() == D);
    if (acc_ok) sb.push_back(dot());
    chk("busy_after_start", busy, acc_ok);
  endtask

  task automatic wait_res(input bit rnd);
    int tgt, n;
    tgt = nres + 1;
    n = 0;
    while (nres < tgt && n < 400) begin
      if (rnd) begin
        ena = ($urandom_range(0, 3) != 0);
        out_ready = $urandom_range(0, 1);
      end else begin
        ena = 1'b1; out_ready = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    ena = 1'b1; out_ready = 1'b0;
    chk("result_timeout", nres >= tgt, 1);
    chk("in_ready_after", in_ready, 1);
    chk("full_retained", full, 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    mclear();
    chk("full_after_clear", full, 0);
  endtask

  initial begin
    bit ok;
    int lat;
    rst_n = 1'b0; ena = 1'b1; clear = 1'b0; in_valid = 1'b0; start = 1'b0;
    out_ready = 1'b0; in_a = '0; in_b = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_full", full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill: 15 pairs is not full, start ignored; 16th makes it full.
    for (int i = 0; i < D - 1; i++) push(8'd3, 8'd5);
    chk("full_at_15", full, 0);
    try_start(ok);
    push(8'd3, 8'd5);
    chk("full_at_16", full, 1);

    // Constant window with latency measurement and a 5-cycle stall.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back(dot());
    chk("const_model", sb[sb.size()-1], 240);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    // Cycle T+1 follows the start edge, so out_valid in cycle T+D+1 is D edges later.
    chk("latency_edges", lat, D);
    repeat (5) begin @(posedge clk); #1; end
    wait_res(0);

    // Sliding window: a=0..19, b=1 leaves 4..19.
    do_clear();
    for (int i = 0; i < 20; i++) push(8'(i), 8'd1);
    try_start(ok);
    chk("sliding_model", sb[sb.size()-1], 184);
    wait_res(0);

    // Extremes.
    do_clear();
    for (int i = 0; i < D; i++) push(8'hFF, 8'hFF);
    try_start(ok);
    wait_res(0);
`ifdef CORR_SIGNED_EN
    for (int i = 0; i < D; i++) push(8'h80, 8'h80);
    try_start(ok);
    chk("neg_sq_model", sb[sb.size()-1], 262144);
    wait_res(0);
    for (int i = 0; i < D; i++) push(8'h80, 8'h7F);
    try_start(ok);
    chk("neg_pos_model", sb[sb.size()-1], 20'(-260096));
    wait_res(0);
`else
    chk("ff_model", dot(), 1040400);
`endif

    // clear beats start.
    clear = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0;
    mclear();
    chk("clr_start_busy", busy, 0);
    chk("clr_start_full", full, 0);

    // Same-cycle write joins the window at start.
    for (int i = 0; i < D; i++) push(8'd0, 8'd1);
    in_valid = 1'b1; in_a = 8'd7; in_b = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; start = 1'b0;
    mpush(8'd7, 8'd1);
    sb.push_back(dot());
    chk("start_wr_model", sb[sb.size()-1], 7);
    chk("start_wr_busy", busy, 1);
    wait_res(0);

    // Reset partway through COMPUTE.
    try_start(ok);
    repeat (7) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    sb.delete();
    mclear();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_full", full, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < D; i++) push(8'($urandom), 8'($urandom));
    try_start(ok);
    chk("fresh_accept", ok, 1);
    wait_res(0);

    // Randomized traffic with enable gaps and back-pressure.
    rnd_ena = 1;
    for (int r = 0; r < 30; r++) begin
      int n;
      if ($urandom_range(0, 5) == 0) do_clear();
      n = $urandom_range(0, 24);
      for (int i = 0; i < n; i++) push(8'($urandom), 8'($urandom));
      try_start(ok);
      if (ok) wait_res(1);
    end
    rnd_ena = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
